ccu_snoop_sequencer: RTL and testbench



---
 rtl/ccu_snoop_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_ccu_snoop_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccu_snoop_sequencer.sv
`timescale 1ns/1ps
// ccu_snoop_sequencer
// Round-robin arbitration of coherent snoop requests from the ACE ports of
// the CCU. A granted snoop is broadcast on AC to every port except its
// initiator, the CR answers are OR-combined, and the aggregated response plus
// the mask of ports that will push CD data is presented on the rsp channel.
//
// Handshake rule for every channel (req, ac, cr, rsp): a transfer happens on a
// rising clk_i edge where valid and ready are both high. Once a sender raises
// valid it keeps valid and payload stable until that edge. Only req_ready_o
// looks at its own valid combinationally; every other output is decoded from
// registered state.
module ccu_snoop_sequencer #(
    parameter int unsigned NoSlvPorts   = 4,
    parameter int unsigned AxiAddrWidth = 64,
    parameter int unsigned IdxWidth     = (NoSlvPorts > 1) ? $clog2(NoSlvPorts) : 1
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NoSlvPorts-1:0]              req_valid_i,
    output logic [NoSlvPorts-1:0]              req_ready_o,
    input  logic [NoSlvPorts*AxiAddrWidth-1:0] req_addr_i,
    input  logic [NoSlvPorts*4-1:0]            req_snoop_i,
    input  logic [NoSlvPorts*3-1:0]            req_prot_i,
    output logic [NoSlvPorts-1:0]              ac_valid_o,
    input  logic [NoSlvPorts-1:0]              ac_ready_i,
    output logic [AxiAddrWidth-1:0]            ac_addr_o,
    output logic [3:0]                         ac_snoop_o,
    output logic [2:0]                         ac_prot_o,
    input  logic [NoSlvPorts-1:0]              cr_valid_i,
    output logic [NoSlvPorts-1:0]              cr_ready_o,
    input  logic [NoSlvPorts*5-1:0]            cr_resp_i,
    output logic                               rsp_valid_o,
    input  logic                               rsp_ready_i,
    output logic [IdxWidth-1:0]                rsp_idx_o,
    output logic [4:0]                         rsp_resp_o,
    output logic [NoSlvPorts-1:0]              rsp_data_mask_o,
    output logic [1:0]                         dbg_state_o
);

    typedef enum logic [1:0] {
        Idle  = 2'd0,
        Snoop = 2'd1,
        Resp  = 2'd2
    } stateT;

    stateT                     stateQ, stateD;
    logic [IdxWidth-1:0]       rrQ;
    logic [IdxWidth-1:0]       idxQ;
    logic [AxiAddrWidth-1:0]   addrQ;
    logic [3:0]                snoopQ;
    logic [2:0]                protQ;
    logic [NoSlvPorts-1:0]     targetQ;
    logic [NoSlvPorts-1:0]     acDoneQ;
    logic [NoSlvPorts-1:0]     crDoneQ;
    logic [4:0]                respQ;
    logic [NoSlvPorts-1:0]     dataMaskQ;

    logic                      grantFound;
    logic [IdxWidth-1:0]       grantIdx;
    logic [IdxWidth-1:0]       candIdx;
    logic [IdxWidth-1:0]       rrNext;
    logic [NoSlvPorts-1:0]     targetNew;
    logic                      reqFire;
    logic [NoSlvPorts-1:0]     acValid;
    logic [NoSlvPorts-1:0]     crReady;
    logic [NoSlvPorts-1:0]     acFire;
    logic [NoSlvPorts-1:0]     crFire;
    logic [NoSlvPorts-1:0]     crDoneNext;
    logic [4:0]                respOr;
    logic [NoSlvPorts-1:0]     dataNew;

    // Round-robin scan starting at rrQ; first requesting port wins.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        candIdx    = '0;
        for (int unsigned i = 0; i < NoSlvPorts; i++) begin
            candIdx = IdxWidth'((32'(rrQ) + i) % NoSlvPorts);
            if (!grantFound && req_valid_i[candIdx]) begin
                grantFound = 1'b1;
                grantIdx   = candIdx;
            end
        end
    end

    // Pointer advance, target mask and one-hot ready for the current grant.
    always_comb begin
        rrNext = (grantIdx == IdxWidth'(NoSlvPorts - 1)) ? '0 : grantIdx + IdxWidth'(1);
        targetNew           = '1;
        targetNew[grantIdx] = 1'b0;
        req_ready_o         = '0;
        if (stateQ == Idle && grantFound) begin
            req_ready_o[grantIdx] = 1'b1;
        end
    end

    assign reqFire = (stateQ == Idle) && grantFound;

    // AC/CR enables decode only registered masks; a CR needs its AC already done.
    always_comb begin
        acValid = '0;
        crReady = '0;
        if (stateQ == Snoop) begin
            acValid = targetQ & ~acDoneQ;
            crReady = targetQ & acDoneQ & ~crDoneQ;
        end
    end

    assign acFire     = acValid & ac_ready_i;
    assign crFire     = crReady & cr_valid_i;
    assign crDoneNext = crDoneQ | crFire;

    // Field-wise OR of every CR accepted this cycle; bit 0 is dataTransfer.
    always_comb begin
        respOr  = '0;
        dataNew = '0;
        for (int unsigned j = 0; j < NoSlvPorts; j++) begin
            if (crFire[j]) begin
                respOr     = respOr | cr_resp_i[j*5 +: 5];
                dataNew[j] = cr_resp_i[j*5];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stateQ <= Idle;
        end else begin
            stateQ <= stateD;
        end
    end

    // FSM next-state logic.
    always_comb begin
        stateD = stateQ;
        case (stateQ)
            Idle: begin
                if (grantFound) begin
                    // With a single port there is nobody to snoop.
                    stateD = (targetNew == '0) ? Resp : Snoop;
                end
            end
            Snoop: begin
                if (crDoneNext == targetQ) begin
                    stateD = Resp;
                end
            end
            Resp: begin
                if (rsp_ready_i) begin
                    stateD = Idle;
                end
            end
            default: stateD = Idle;
        endcase
    end

    // Transaction registers: latched on grant, accumulated during SNOOP.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rrQ       <= '0;
            idxQ      <= '0;
            addrQ     <= '0;
            snoopQ    <= '0;
            protQ     <= '0;
            targetQ   <= '0;
            acDoneQ   <= '0;
            crDoneQ   <= '0;
            respQ     <= '0;
            dataMaskQ <= '0;
        end else if (reqFire) begin
            rrQ       <= rrNext;
            idxQ      <= grantIdx;
            addrQ     <= req_addr_i[grantIdx*AxiAddrWidth +: AxiAddrWidth];
            snoopQ    <= req_snoop_i[grantIdx*4 +: 4];
            protQ     <= req_prot_i[grantIdx*3 +: 3];
            targetQ   <= targetNew;
            acDoneQ   <= '0;
            crDoneQ   <= '0;
            respQ     <= '0;
            dataMaskQ <= '0;
        end else if (stateQ == Snoop) begin
            acDoneQ   <= acDoneQ | acFire;
            crDoneQ   <= crDoneNext;
            respQ     <= respQ | respOr;
            dataMaskQ <= dataMaskQ | dataNew;
        end
    end

    assign ac_valid_o      = acValid;
    assign cr_ready_o      = crReady;
    assign ac_addr_o       = addrQ;
    assign ac_snoop_o      = snoopQ;
    assign ac_prot_o       = protQ;
    assign rsp_valid_o     = (stateQ == Resp);
    assign rsp_idx_o       = idxQ;
    assign rsp_resp_o      = respQ;
    assign rsp_data_mask_o = dataMaskQ;
    assign dbg_state_o     = stateQ;

endmodule

// File: tb/tb_ccu_snoop_sequencer.sv
`timescale 1ns/1ps
// Directed bench for ccu_snoop_sequencer with four ports: a table of complete
// minimum-latency transactions followed by hand-written multi-cycle sequences.
module tb_ccu_snoop_sequencer;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int IW = 2;
    localparam int SW = IW + 5 + N;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [N-1:0]      req_valid_i = '0;
    logic [N-1:0]      req_ready_o;
    logic [N*AW-1:0]   req_addr_i = '0;
    logic [N*4-1:0]    req_snoop_i = '0;
    logic [N*3-1:0]    req_prot_i = '0;
    logic [N-1:0]      ac_valid_o;
    logic [N-1:0]      ac_ready_i = '0;
    logic [AW-1:0]     ac_addr_o;
    logic [3:0]        ac_snoop_o;
    logic [2:0]        ac_prot_o;
    logic [N-1:0]      cr_valid_i = '0;
    logic [N-1:0]      cr_ready_o;
    logic [N*5-1:0]    cr_resp_i = '0;
    logic              rsp_valid_o;
    logic              rsp_ready_i = 1'b0;
    logic [IW-1:0]     rsp_idx_o;
    logic [4:0]        rsp_resp_o;
    logic [N-1:0]      rsp_data_mask_o;
    logic [1:0]        dbg_state_o;

    typedef struct {
        logic [N-1:0]      req;
        logic [AW-1:0]     addr;
        logic [3:0]        snoop;
        logic [2:0]        prot;
        logic [N-1:0][4:0] cr;
        logic [IW-1:0]     idx;
        logic [4:0]        resp;
        logic [N-1:0]      mask;
    } vecT;

    vecT         vecs [10];
    logic [SW-1:0] expQ [$];
    int          chkCnt = 0;
    int          passCnt = 0;

    ccu_snoop_sequencer #(
        .NoSlvPorts   (N),
        .AxiAddrWidth (AW)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_addr_i      (req_addr_i),
        .req_snoop_i     (req_snoop_i),
        .req_prot_i      (req_prot_i),
        .ac_valid_o      (ac_valid_o),
        .ac_ready_i      (ac_ready_i),
        .ac_addr_o       (ac_addr_o),
        .ac_snoop_o      (ac_snoop_o),
        .ac_prot_o       (ac_prot_o),
        .cr_valid_i      (cr_valid_i),
        .cr_ready_o      (cr_ready_o),
        .cr_resp_i       (cr_resp_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready_i),
        .rsp_idx_o       (rsp_idx_o),
        .rsp_resp_o      (rsp_resp_o),
        .rsp_data_mask_o (rsp_data_mask_o),
        .dbg_state_o     (dbg_state_o)
    );

    // Clock and watchdog.
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chkCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Port p sees addr + p*0x100, snoop ^ p, prot ^ p so the payload mux is visible.
    task automatic driveReq(input logic [N-1:0] mask, input logic [AW-1:0] addr,
                            input logic [3:0] snoop, input logic [2:0] prot);
        for (int p = 0; p < N; p++) begin
            req_addr_i[p*AW +: AW] = addr + 64'(p) * 64'h100;
            req_snoop_i[p*4 +: 4]  = snoop ^ 4'(p);
            req_prot_i[p*3 +: 3]   = prot ^ 3'(p);
        end
        req_valid_i = mask;
    endtask

    task automatic checkZero(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready_o), 64'h0);
        chk({tag, "_ac_valid"},  64'(ac_valid_o), 64'h0);
        chk({tag, "_cr_ready"},  64'(cr_ready_o), 64'h0);
        chk({tag, "_ac_addr"},   ac_addr_o, 64'h0);
        chk({tag, "_ac_snoop"},  64'(ac_snoop_o), 64'h0);
        chk({tag, "_ac_prot"},   64'(ac_prot_o), 64'h0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'h0);
        chk({tag, "_rsp"},       64'({rsp_idx_o, rsp_resp_o, rsp_data_mask_o}), 64'h0);
        chk({tag, "_state"},     64'(dbg_state_o), 64'h0);
    endtask

    // One minimum-latency transaction; called at posedge+1 of an IDLE cycle.
    task automatic runVec(input int n, input vecT v);
        logic [N-1:0] tgt;
        string tag;
        tag = $sformatf("v%0d", n);
        tgt = ~(N'(1) << v.idx);
        expQ.push_back({v.idx, v.resp, v.mask});
        driveReq(v.req, v.addr, v.snoop, v.prot);
        ac_ready_i = '1;
        cr_valid_i = '0;
        @(negedge clk_i);
        chk({tag, "_grant"}, 64'(req_ready_o), 64'(N'(1) << v.idx));
        chk({tag, "_rsp_valid_t0"}, 64'(rsp_valid_o), 64'h0);
        tick();
        // t1: AC broadcast; CR offered on every port including the initiator.
        cr_resp_i  = v.cr;
        cr_valid_i = '1;
        @(negedge clk_i);
        chk({tag, "_ac_valid"}, 64'(ac_valid_o), 64'(tgt));
        chk({tag, "_ac_addr"}, ac_addr_o, v.addr + 64'(v.idx) * 64'h100);
        chk({tag, "_ac_snoop"}, 64'(ac_snoop_o), 64'(v.snoop ^ 4'(v.idx)));
        chk({tag, "_ac_prot"}, 64'(ac_prot_o), 64'(v.prot ^ 3'(v.idx)));
        chk({tag, "_cr_ready_t1"}, 64'(cr_ready_o), 64'h0);
        chk({tag, "_req_ready_t1"}, 64'(req_ready_o), 64'h0);
        chk({tag, "_state_t1"}, 64'(dbg_state_o), 64'h1);
        tick();
        @(negedge clk_i);
        chk({tag, "_ac_valid_t2"}, 64'(ac_valid_o), 64'h0);
        chk({tag, "_cr_ready_t2"}, 64'(cr_ready_o), 64'(tgt));
        chk({tag, "_rsp_valid_t2"}, 64'(rsp_valid_o), 64'h0);
        tick();
        cr_valid_i = '0;
        @(negedge clk_i);
        chk({tag, "_rsp_valid_t3"}, 64'(rsp_valid_o), 64'h1);
        chk({tag, "_rsp"}, 64'({rsp_idx_o, rsp_resp_o, rsp_data_mask_o}), 64'(expQ.pop_front()));
        chk({tag, "_cr_ready_t3"}, 64'(cr_ready_o), 64'h0);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
    endtask

    initial begin
        // Stimulus table: initiator payload, CR per port {p3,p2,p1,p0}, expected result.
        vecs[0] = '{req:4'b0100, addr:64'h0E00, snoop:4'b0011, prot:3'b010,
                    cr:{5'h00, 5'h1f, 5'h00, 5'b01001}, idx:2'd2, resp:5'b01001, mask:4'b0001};
        vecs[1] = '{req:4'b1111, addr:64'h4000, snoop:4'b1010, prot:3'b001,
                    cr:{5'h1f, 5'b00001, 5'b00100, 5'b10000}, idx:2'd3, resp:5'b10101, mask:4'b0100};
        vecs[2] = '{req:4'b1111, addr:64'h5000, snoop:4'b0111, prot:3'b100,
                    cr:{5'b01000, 5'h00, 5'b00010, 5'h1f}, idx:2'd0, resp:5'b01010, mask:4'b0000};
        vecs[3] = '{req:4'b1111, addr:64'h6000, snoop:4'b1100, prot:3'b011,
                    cr:{5'b00011, 5'b00001, 5'h1f, 5'b00001}, idx:2'd1, resp:5'b00011, mask:4'b1101};
        vecs[4] = '{req:4'b1111, addr:64'h7000, snoop:4'b0001, prot:3'b111,
                    cr:{5'h00, 5'h1f, 5'h00, 5'h00}, idx:2'd2, resp:5'b00000, mask:4'b0000};
        vecs[5] = '{req:4'b1111, addr:64'h8000, snoop:4'b1000, prot:3'b000,
                    cr:{5'h1f, 5'h00, 5'h00, 5'h1f}, idx:2'd3, resp:5'b11111, mask:4'b0001};
        vecs[6] = '{req:4'b1111, addr:64'h9000, snoop:4'b0101, prot:3'b110,
                    cr:{5'h00, 5'b01000, 5'b00101, 5'h1f}, idx:2'd0, resp:5'b01101, mask:4'b0010};
        vecs[7] = '{req:4'b1010, addr:64'hA000, snoop:4'b1110, prot:3'b101,
                    cr:{5'b00001, 5'b10000, 5'h1f, 5'h00}, idx:2'd1, resp:5'b10001, mask:4'b1000};
        vecs[8] = '{req:4'b1010, addr:64'hB000, snoop:4'b0010, prot:3'b010,
                    cr:{5'h1f, 5'h00, 5'b00001, 5'b01000}, idx:2'd3, resp:5'b01001, mask:4'b0010};
        vecs[9] = '{req:4'b0001, addr:64'hC000, snoop:4'b1011, prot:3'b001,
                    cr:{5'h00, 5'b00110, 5'h00, 5'h1f}, idx:2'd0, resp:5'b00110, mask:4'b0000};

        // Reset state.
        #1;
        checkZero("reset");
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        #2 rst_ni = 1'b1;
        tick();

        // Table: single requester, then continuous all-port grants 3,0,1,2,3,0, then sparse.
        for (int n = 0; n < 10; n++) runVec(n, vecs[n]);

        // Staggered AC on port 3, CR in order 1,3,0, then a 10-cycle stalled response.
        driveReq(4'b0100, 64'h2000, 4'b0111, 3'b010);
        ac_ready_i = 4'b0011;
        cr_valid_i = '0;
        @(negedge clk_i);
        chk("stag_grant", 64'(req_ready_o), 64'h4);
        tick();
        driveReq(4'b0000, 64'hDEAD_0000, 4'hF, 3'h7);
        @(negedge clk_i);
        chk("stag_ac_valid_a", 64'(ac_valid_o), 64'hB);
        chk("stag_cr_ready_a", 64'(cr_ready_o), 64'h0);
        tick();
        cr_resp_i  = {5'h00, 5'h00, 5'b00100, 5'h00};
        cr_valid_i = 4'b0010;
        @(negedge clk_i);
        chk("stag_ac_valid_b", 64'(ac_valid_o), 64'h8);
        chk("stag_cr_ready_b", 64'(cr_ready_o), 64'h3);
        tick();
        cr_valid_i = '0;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) ac_ready_i = 4'b1011;
            @(negedge clk_i);
            chk("stag_ac_hold", 64'(ac_valid_o), 64'h8);
            chk("stag_ac_addr", ac_addr_o, 64'h2200);
            chk("stag_ac_payload", 64'({ac_snoop_o, ac_prot_o}), 64'({4'b0101, 3'b000}));
            chk("stag_cr_ready_hold", 64'(cr_ready_o), 64'h1);
            chk("stag_rsp_hold", 64'(rsp_valid_o), 64'h0);
            tick();
        end
        ac_ready_i = '0;
        cr_resp_i  = {5'b01000, 5'h00, 5'h00, 5'h00};
        cr_valid_i = 4'b1000;
        @(negedge clk_i);
        chk("stag_ac_valid_f", 64'(ac_valid_o), 64'h0);
        chk("stag_cr_ready_f", 64'(cr_ready_o), 64'h9);
        tick();
        cr_resp_i  = {5'h00, 5'h00, 5'h00, 5'b00001};
        cr_valid_i = 4'b0001;
        @(negedge clk_i);
        chk("stag_cr_ready_g", 64'(cr_ready_o), 64'h1);
        chk("stag_rsp_g", 64'(rsp_valid_o), 64'h0);
        tick();
        cr_valid_i = '0;
        expQ.push_back({2'd2, 5'b01101, 4'b0001});
        driveReq(4'b0100, 64'h3000, 4'b0010, 3'b001);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            chk("stall_rsp_valid", 64'(rsp_valid_o), 64'h1);
            chk("stall_rsp", 64'({rsp_idx_o, rsp_resp_o, rsp_data_mask_o}), 64'(expQ[0]));
            chk("stall_req_ready", 64'(req_ready_o), 64'h0);
            chk("stall_ac_addr", ac_addr_o, 64'h2200);
            tick();
        end
        void'(expQ.pop_front());
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;

        // Same-cycle CR from ports 0 and 1.
        ac_ready_i = '1;
        @(negedge clk_i);
        chk("same_grant", 64'(req_ready_o), 64'h4);
        tick();
        req_valid_i = '0;
        @(negedge clk_i);
        chk("same_ac_valid", 64'(ac_valid_o), 64'hB);
        chk("same_ac_addr", ac_addr_o, 64'h3200);
        tick();
        cr_resp_i  = {5'h00, 5'h00, 5'b00010, 5'b00101};
        cr_valid_i = 4'b0011;
        @(negedge clk_i);
        chk("same_cr_ready", 64'(cr_ready_o), 64'hB);
        tick();
        cr_resp_i  = '0;
        cr_valid_i = 4'b1000;
        @(negedge clk_i);
        chk("same_cr_ready_last", 64'(cr_ready_o), 64'h8);
        chk("same_rsp_early", 64'(rsp_valid_o), 64'h0);
        tick();
        cr_valid_i = '0;
        @(negedge clk_i);
        chk("same_rsp_valid", 64'(rsp_valid_o), 64'h1);
        chk("same_rsp", 64'({rsp_idx_o, rsp_resp_o, rsp_data_mask_o}), 64'({2'd2, 5'b00111, 4'b0001}));
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;

        // Reset in the middle of a snoop, then a fresh arbitration.
        driveReq(4'b0010, 64'hE000, 4'b0110, 3'b100);
        ac_ready_i = '0;
        @(negedge clk_i);
        chk("rst_pre_grant", 64'(req_ready_o), 64'h2);
        tick();
        req_valid_i = '0;
        @(negedge clk_i);
        chk("rst_pre_ac_valid", 64'(ac_valid_o), 64'hD);
        #2 rst_ni = 1'b0;
        #1;
        checkZero("mid_rst");
        @(negedge clk_i);
        #2 rst_ni = 1'b1;
        tick();
        driveReq(4'b1010, 64'hF000, 4'b1001, 3'b011);
        ac_ready_i = '1;
        @(negedge clk_i);
        chk("post_rst_grant", 64'(req_ready_o), 64'h2);
        tick();
        req_valid_i = '0;
        @(negedge clk_i);
        chk("post_rst_ac_valid", 64'(ac_valid_o), 64'hD);
        chk("post_rst_ac_addr", ac_addr_o, 64'hF100);
        chk("post_rst_cr_ready", 64'(cr_ready_o), 64'h0);
        tick();
        cr_resp_i  = {5'b00010, 5'b00001, 5'h1f, 5'h00};
        cr_valid_i = '1;
        @(negedge clk_i);
        chk("post_rst_cr_ready_b", 64'(cr_ready_o), 64'hD);
        tick();
        cr_valid_i = '0;
        @(negedge clk_i);
        chk("post_rst_rsp_valid", 64'(rsp_valid_o), 64'h1);
        chk("post_rst_rsp", 64'({rsp_idx_o, rsp_resp_o, rsp_data_mask_o}), 64'({2'd1, 5'b00011, 4'b0100}));
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        @(negedge clk_i);
        chk("final_idle", 64'(dbg_state_o), 64'h0);

        $display("%0d/%0d checks passed", passCnt, chkCnt);
        $finish;
    end

endmodule
